// File: rtl/alu_regfile_wb.sv
// Register file + one-entry pending writeback stage for the 16-bit ALU.
// Optional macro ALU_REGFILE_BYPASS_EN forwards the pending entry to the read ports.
module alu_regfile_wb #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREGS = 8,
   parameter int unsigned AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    ra_addr,
   input  logic [AW-1:0]    rb_addr,
   output logic [WIDTH-1:0] a_data,
   output logic [WIDTH-1:0] b_data,
   input  logic             wb_valid,
   input  logic [AW-1:0]    wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             wb_flags_en,
   input  logic             wb_zero,
   input  logic             wb_sign,
   output logic             zero_flag,
   output logic             sign_flag,
   output logic             raw_hazard
);

   logic [WIDTH-1:0] regs [NREGS];

   logic             pend_valid;
   logic [AW-1:0]    pend_addr;
   logic [WIDTH-1:0] pend_data;
   logic             pend_flags_en;
   logic             pend_zero;
   logic             pend_sign;

   // Capture the new result and commit the previous one on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         pend_valid    <= 1'b0;
         pend_addr     <= '0;
         pend_data     <= '0;
         pend_flags_en <= 1'b0;
         pend_zero     <= 1'b0;
         pend_sign     <= 1'b0;
         zero_flag     <= 1'b0;
         sign_flag     <= 1'b0;
      end else begin
         pend_valid    <= wb_valid;
         pend_addr     <= wb_addr;
         pend_data     <= wb_data;
         pend_flags_en <= wb_flags_en;
         pend_zero     <= wb_zero;
         pend_sign     <= wb_sign;
         if (pend_valid && pend_addr != '0) begin
            regs[pend_addr] <= pend_data;
         end
         // r0 still updates flags, so it serves as a compare-only destination.
         if (pend_valid && pend_flags_en) begin
            zero_flag <= pend_zero;
            sign_flag <= pend_sign;
         end
      end
   end

   logic pend_live;
   assign pend_live = pend_valid && (pend_addr != '0);

   always_comb begin
      a_data = (ra_addr == '0) ? '0 : regs[ra_addr];
      b_data = (rb_addr == '0) ? '0 : regs[rb_addr];
`ifdef ALU_REGFILE_BYPASS_EN
      if (pend_live && pend_addr == ra_addr) begin
         a_data = pend_data;
      end
      if (pend_live && pend_addr == rb_addr) begin
         b_data = pend_data;
      end
      raw_hazard = 1'b0;
`else
      raw_hazard = pend_live && ((pend_addr == ra_addr) || (pend_addr == rb_addr));
`endif
   end

endmodule

// File: tb/tb_alu_regfile_wb.sv
// Directed self-checking bench for alu_regfile_wb; expectations follow ALU_REGFILE_BYPASS_EN.
module tb_alu_regfile_wb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  ra_addr, rb_addr, wb_addr;
   logic [15:0] a_data, b_data, wb_data;
   logic        wb_valid, wb_flags_en, wb_zero, wb_sign;
   logic        zero_flag, sign_flag, raw_hazard;

   int tests = 0;
   int fails = 0;

`ifdef ALU_REGFILE_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   alu_regfile_wb #(.WIDTH(16), .NREGS(8), .AW(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ra_addr     (ra_addr),
      .rb_addr     (rb_addr),
      .a_data      (a_data),
      .b_data      (b_data),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .wb_flags_en (wb_flags_en),
      .wb_zero     (wb_zero),
      .wb_sign     (wb_sign),
      .zero_flag   (zero_flag),
      .sign_flag   (sign_flag),
      .raw_hazard  (raw_hazard)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [2:0] addr, input logic [15:0] data,
                        input logic fen, input logic z, input logic s);
      wb_valid    = v;
      wb_addr     = addr;
      wb_data     = data;
      wb_flags_en = fen;
      wb_zero     = z;
      wb_sign     = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      tests++; if (a_data !== 16'h0 || b_data !== 16'h0) begin fails++;
         $display("FAIL reset_init_reads a=%h b=%h exp 0", a_data, b_data); end
      tests++; if ({zero_flag, sign_flag, raw_hazard} !== 3'b000) begin fails++;
         $display("FAIL reset_init_flags z/s/h=%b exp 000", {zero_flag, sign_flag, raw_hazard}); end
      tick();
      rst_n = 1'b1;
      drive(1, 3'd6, 16'h5555, 1, 1, 0);
      tick();
      drive(1, 3'd4, 16'hBEEF, 0, 0, 0);
      tick();
      drive(0, 3'd0, 16'h0, 0, 0, 0);
      ra_addr = 3'd6; rb_addr = 3'd4;
      #1;
      tests++; if (a_data !== 16'h5555 || zero_flag !== 1'b1) begin fails++;
         $display("FAIL reset_pre_commit a=%h z=%b exp 5555 1", a_data, zero_flag); end
      #1 rst_n = 1'b0;
      #1;
      tests++; if (a_data !== 16'h0 || b_data !== 16'h0) begin fails++;
         $display("FAIL reset_async_reads a=%h b=%h exp 0", a_data, b_data); end
      tests++; if ({zero_flag, sign_flag, raw_hazard} !== 3'b000) begin fails++;
         $display("FAIL reset_async_flags z/s/h=%b exp 000", {zero_flag, sign_flag, raw_hazard}); end
      #1 rst_n = 1'b1;
      tick();
      tick();
      tests++; if (a_data !== 16'h0 || b_data !== 16'h0 || zero_flag !== 1'b0) begin fails++;
         $display("FAIL reset_discard a=%h b=%h z=%b exp 0 0 0", a_data, b_data, zero_flag); end
   endtask

   task automatic test_basic_write();
      drive(1, 3'd3, 16'h1234, 1, 0, 0);
      ra_addr = 3'd3; rb_addr = 3'd0;
      tick();
      drive(0, 3'd0, 16'h0, 0, 0, 0);
      tests++; if (a_data !== (Bypass ? 16'h1234 : 16'h0)) begin fails++;
         $display("FAIL basic_pending a=%h exp %h", a_data, Bypass ? 16'h1234 : 16'h0); end
      tick();
      tests++; if (a_data !== 16'h1234 || zero_flag !== 1'b0 || sign_flag !== 1'b0) begin fails++;
         $display("FAIL basic_commit a=%h z=%b s=%b exp 1234 0 0", a_data, zero_flag, sign_flag); end
   endtask

   task automatic test_r0_write();
      drive(1, 3'd0, 16'hFFFF, 1, 0, 1);
      ra_addr = 3'd0; rb_addr = 3'd0;
      tick();
      drive(0, 3'd0, 16'h0, 0, 0, 0);
      tests++; if (raw_hazard !== 1'b0 || a_data !== 16'h0) begin fails++;
         $display("FAIL r0_pending h=%b a=%h exp 0 0", raw_hazard, a_data); end
      tick();
      tests++; if (a_data !== 16'h0 || b_data !== 16'h0 || sign_flag !== 1'b1 || zero_flag !== 1'b0)
         begin fails++;
         $display("FAIL r0_commit a=%h b=%h s=%b z=%b exp 0 0 1 0", a_data, b_data, sign_flag,
                  zero_flag); end
   endtask

   task automatic test_raw_hazard();
      drive(1, 3'd5, 16'h00AA, 0, 0, 0);
      ra_addr = 3'd5; rb_addr = 3'd1;
      tick();
      drive(0, 3'd0, 16'h0, 0, 0, 0);
      tests++; if (raw_hazard !== !Bypass || a_data !== (Bypass ? 16'h00AA : 16'h0)) begin fails++;
         $display("FAIL raw_port_a h=%b a=%h exp %b %h", raw_hazard, a_data, !Bypass,
                  Bypass ? 16'h00AA : 16'h0); end
      ra_addr = 3'd2; rb_addr = 3'd5;
      #1;
      tests++; if (raw_hazard !== !Bypass || b_data !== (Bypass ? 16'h00AA : 16'h0)) begin fails++;
         $display("FAIL raw_port_b h=%b b=%h exp %b", raw_hazard, b_data, !Bypass); end
      rb_addr = 3'd2;
      #1;
      tests++; if (raw_hazard !== 1'b0) begin fails++;
         $display("FAIL raw_miss h=%b exp 0", raw_hazard); end
      ra_addr = 3'd5;
      tick();
      tests++; if (a_data !== 16'h00AA || raw_hazard !== 1'b0) begin fails++;
         $display("FAIL raw_commit a=%h h=%b exp 00aa 0", a_data, raw_hazard); end
   endtask

   task automatic test_back_to_back();
      drive(1, 3'd2, 16'h0001, 1, 0, 0);
      ra_addr = 3'd2; rb_addr = 3'd2;
      tick();
      drive(1, 3'd2, 16'h8000, 1, 0, 1);
      tick();
      drive(0, 3'd0, 16'h0, 0, 0, 0);
      tests++; if (a_data !== (Bypass ? 16'h8000 : 16'h0001) || sign_flag !== 1'b0) begin fails++;
         $display("FAIL b2b_first a=%h s=%b exp %h 0", a_data, sign_flag,
                  Bypass ? 16'h8000 : 16'h0001); end
      tick();
      tests++; if (a_data !== 16'h8000 || b_data !== 16'h8000 || sign_flag !== 1'b1) begin fails++;
         $display("FAIL b2b_last a=%h b=%h s=%b exp 8000 8000 1", a_data, b_data, sign_flag); end
   endtask

   task automatic test_stream();
      logic [15:0] ea, eb;
      logic        eh;
      for (int i = 1; i <= 7; i++) begin
         drive(1, 3'(i), 16'(i * 'h1111), 0, 0, 0);
         tick();
         if (i >= 2) begin
            ra_addr = 3'(i - 1); rb_addr = 3'd0;
            #1;
            tests++; if (a_data !== 16'((i - 1) * 'h1111) || raw_hazard !== 1'b0) begin fails++;
               $display("FAIL stream_commit r%0d a=%h h=%b exp %h 0", i - 1, a_data, raw_hazard,
                        16'((i - 1) * 'h1111)); end
         end
      end
      drive(0, 3'd0, 16'h0, 0, 0, 0);
      // r7 is still pending; it held 0 since reset.
      for (int i = 1; i <= 7; i++) begin
         ra_addr = 3'(i);
         rb_addr = 3'((i % 7) + 1);
         ea = (i == 7 && !Bypass) ? 16'h0 : 16'(i * 'h1111);
         eb = ((i % 7) + 1 == 7 && !Bypass) ? 16'h0 : 16'(((i % 7) + 1) * 'h1111);
         eh = !Bypass && (i == 7 || i == 6);
         #1;
         tests++; if (a_data !== ea || b_data !== eb || raw_hazard !== eh) begin fails++;
            $display("FAIL stream_pair ra=%0d a=%h b=%h h=%b exp %h %h %b", i, a_data, b_data,
                     raw_hazard, ea, eb, eh); end
      end
      tick();
      ra_addr = 3'd7; rb_addr = 3'd3;
      #1;
      tests++; if (a_data !== 16'h7777 || b_data !== 16'h3333 || raw_hazard !== 1'b0) begin fails++;
         $display("FAIL stream_final a=%h b=%h h=%b exp 7777 3333 0", a_data, b_data, raw_hazard); end
   endtask

   initial begin
      rst_n = 1'b0;
      ra_addr = 3'd0; rb_addr = 3'd0;
      drive(0, 3'd0, 16'h0, 0, 0, 0);
      test_reset();
      test_basic_write();
      test_r0_write();
      test_raw_hazard();
      test_back_to_back();
      test_stream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
